// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX operand skid buffer: default widths, entry layout, occupancy state.
package id_ex_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_AW = 5;
   localparam int DEF_OP_W   = 6;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [DEF_REG_AW-1:0] rs1;
      logic [DEF_REG_AW-1:0] rs2;
      logic [DEF_REG_AW-1:0] rd;
      logic                  reg_write;
      logic [DEF_OP_W-1:0]   op;
      logic [DEF_DATA_W-1:0] opa;
      logic [DEF_DATA_W-1:0] opb;
   } entry_t;

endpackage

// File: rtl/operand_bypass_mux.sv
// Selects register-file writeback data over a stored operand when the writeback targets
// the operand's source index; index 0 is excluded when ZERO_HARD is set.
module operand_bypass_mux #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int ZERO_HARD = 1
) (
   input  logic [REG_AW-1:0] rs_i,
   input  logic [DATA_W-1:0] stored_i,
   input  logic              wb_reg_write_i,
   input  logic [REG_AW-1:0] wb_reg_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic [DATA_W-1:0] data_o
);

   logic hit;

   assign hit    = wb_reg_write_i && (wb_reg_i == rs_i) &&
                   !((ZERO_HARD != 0) && (rs_i == '0));
   assign data_o = hit ? wb_data_i : stored_i;

endmodule

// File: rtl/id_ex_operand_buffer.sv
// Two-entry skid buffer between decode and execute. Define OPERAND_BYPASS_EN to keep
// buffered operands coherent with register-file writebacks.
module id_ex_operand_buffer
   import id_ex_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int REG_AW    = DEF_REG_AW,
   parameter int OP_W      = DEF_OP_W,
   parameter int ZERO_HARD = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_reg_write,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_rdata1,
   input  logic [DATA_W-1:0] in_rdata2,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_AW-1:0] out_rs1,
   output logic [REG_AW-1:0] out_rs2,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_reg_write,
   output logic [OP_W-1:0]   out_op,
   output logic [DATA_W-1:0] out_opa,
   output logic [DATA_W-1:0] out_opb
);

   state_t state_q, state_d;
   entry_t ent_q [2];
   entry_t ent_d [2];
   entry_t upd [2];
   entry_t cap;
   logic   accept, pop;

   logic [DATA_W-1:0] cap_opa, cap_opb;
   logic [DATA_W-1:0] upd_opa [2];
   logic [DATA_W-1:0] upd_opb [2];

`ifdef OPERAND_BYPASS_EN
   operand_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_HARD(ZERO_HARD)) u_cap_a (
      .rs_i(in_rs1), .stored_i(in_rdata1), .wb_reg_write_i(wb_reg_write),
      .wb_reg_i(wb_reg), .wb_data_i(wb_data), .data_o(cap_opa));
   operand_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_HARD(ZERO_HARD)) u_cap_b (
      .rs_i(in_rs2), .stored_i(in_rdata2), .wb_reg_write_i(wb_reg_write),
      .wb_reg_i(wb_reg), .wb_data_i(wb_data), .data_o(cap_opb));

   // The head's corrected operands double as the combinational out_opa/out_opb.
   for (genvar g = 0; g < 2; g++) begin : g_ent
      operand_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_HARD(ZERO_HARD)) u_a (
         .rs_i(ent_q[g].rs1), .stored_i(ent_q[g].opa), .wb_reg_write_i(wb_reg_write),
         .wb_reg_i(wb_reg), .wb_data_i(wb_data), .data_o(upd_opa[g]));
      operand_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_HARD(ZERO_HARD)) u_b (
         .rs_i(ent_q[g].rs2), .stored_i(ent_q[g].opb), .wb_reg_write_i(wb_reg_write),
         .wb_reg_i(wb_reg), .wb_data_i(wb_data), .data_o(upd_opb[g]));
   end
`else
   logic unused_wb;

   assign cap_opa    = in_rdata1;
   assign cap_opb    = in_rdata2;
   assign upd_opa[0] = ent_q[0].opa;
   assign upd_opa[1] = ent_q[1].opa;
   assign upd_opb[0] = ent_q[0].opb;
   assign upd_opb[1] = ent_q[1].opb;
   assign unused_wb  = ^{wb_reg_write, wb_reg, wb_data, (ZERO_HARD != 0)};
`endif

   assign accept = in_valid && in_ready && !flush;
   assign pop    = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY:   if (accept) state_d = ONE;
            ONE:     if (accept && !pop) state_d = TWO;
                     else if (pop && !accept) state_d = EMPTY;
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q != TWO);
      out_valid = (state_q != EMPTY);
   end

   always_comb begin
      cap.rs1       = in_rs1;
      cap.rs2       = in_rs2;
      cap.rd        = in_rd;
      cap.reg_write = in_reg_write;
      cap.op        = in_op;
      cap.opa       = cap_opa;
      cap.opb       = cap_opb;
      for (int k = 0; k < 2; k++) begin
         upd[k]     = ent_q[k];
         upd[k].opa = upd_opa[k];
         upd[k].opb = upd_opb[k];
         ent_d[k]   = upd[k];
      end
      if (!flush) begin
         case (state_q)
            EMPTY:   if (accept) ent_d[0] = cap;
            ONE:     if (accept && pop) ent_d[0] = cap;
                     else if (accept) ent_d[1] = cap;
            TWO:     if (pop) ent_d[0] = upd[1];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
      end else begin
         ent_q[0] <= ent_d[0];
         ent_q[1] <= ent_d[1];
      end
   end

   assign out_rs1       = ent_q[0].rs1;
   assign out_rs2       = ent_q[0].rs2;
   assign out_rd        = ent_q[0].rd;
   assign out_reg_write = ent_q[0].reg_write;
   assign out_op        = ent_q[0].op;
   assign out_opa       = upd_opa[0];
   assign out_opb       = upd_opb[0];

endmodule
